// File: rtl/wb_master_pipelined.sv
// Pipelined Wishbone B4 initiator.
// Turns a valid/ready command stream into pipelined single transfers and
// returns read data and termination status on a one-cycle response stream.
module wb_master_pipelined #(
  parameter int adr_width       = 16,
  parameter int dat_width       = 16,
  parameter int max_outstanding = 4,
  parameter int timeout         = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [adr_width-1:0] cmd_adr,
  input  logic [dat_width-1:0] cmd_dat,
  input  logic                 cmd_last,
  output logic                 rsp_valid,
  output logic [dat_width-1:0] rsp_dat,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 timeout_flag,
  output logic [adr_width-1:0] wb_adr,
  output logic [dat_width-1:0] wb_dat_o,
  output logic                 wb_we,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  input  logic [dat_width-1:0] wb_dat_i,
  input  logic                 wb_ack,
  input  logic                 wb_err,
  input  logic                 wb_stall
);

  localparam int ow = $clog2(max_outstanding + 1);
  localparam int tw = (timeout > 0) ? $clog2(timeout + 1) : 1;

  // ABORT replays one error response per transfer lost to a timeout.
  typedef enum logic [1:0] {IDLE, BUS, DRAIN, ABORT} state_t;

  state_t                     state_q, state_d;
  logic [ow-1:0]              out_q;
  logic [ow-1:0]              abort_left_q;
  logic [tw-1:0]              timer_q;
  logic                       last_q;
  logic [max_outstanding-1:0] we_fifo_q, we_fifo_d;
  int                         wr_idx;

  logic xfer, term, active, abort, accept;

  assign xfer   = wb_stb & ~wb_stall;
  // Terminations with nothing outstanding are stray and ignored.
  assign term   = (wb_ack | wb_err) & (out_q != '0);
  assign active = (state_q == BUS) | (state_q == DRAIN);
  // A termination in the deadline cycle wins over the abort.
  assign abort  = (timeout != 0) & active & (out_q != '0) & ~term &
                  (timer_q == tw'(timeout));

  // The pending strobe counts toward the limit; a pending last command
  // closes the cycle, so nothing more is taken while it waits or transfers.
  assign cmd_ready = ~rst & ((state_q == IDLE) |
                     ((state_q == BUS) & ~abort & (~wb_stb | ~wb_stall) &
                      ~(wb_stb & last_q) &
                      (int'(out_q) + int'(wb_stb) < max_outstanding)));
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = ~rst & ((state_q != IDLE) | cmd_valid);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS: begin
        if (abort)               state_d = ABORT;
        else if (xfer && last_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                           state_d = ABORT;
        else if (term && out_q == ow'(1))    state_d = IDLE;
      end
      ABORT:   if (abort_left_q <= ow'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-transfer write flag, in issue order; entry 0 is the oldest.
  always_comb begin
    we_fifo_d = we_fifo_q;
    wr_idx    = int'(out_q) - int'(term);
    if (term) we_fifo_d = we_fifo_q >> 1;
    if (xfer) begin
      for (int i = 0; i < max_outstanding; i++) begin
        if (i == wr_idx) we_fifo_d[i] = wb_we;
      end
    end
  end

  // Bus outputs, counters, timer and responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the we FIFO is only a few flops, so it is reset along with the
      // rest; entries at or above the outstanding count are never read.
      we_fifo_q    <= '0;
      wb_cyc       <= 1'b0;
      wb_stb       <= 1'b0;
      wb_adr       <= '0;
      wb_dat_o     <= '0;
      wb_we        <= 1'b0;
      last_q       <= 1'b0;
      out_q        <= '0;
      abort_left_q <= '0;
      timer_q      <= '0;
      timeout_flag <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_dat      <= '0;
    end else begin
      wb_cyc    <= (state_d == BUS) | (state_d == DRAIN);
      we_fifo_q <= we_fifo_d;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
      if (abort) begin
        // In-flight transfers are abandoned; a pending strobe is discarded.
        wb_stb       <= 1'b0;
        out_q        <= '0;
        timer_q      <= '0;
        timeout_flag <= 1'b1;
        abort_left_q <= out_q;
      end else begin
        if (accept) begin
          wb_stb   <= 1'b1;
          wb_adr   <= cmd_adr;
          wb_dat_o <= cmd_dat;
          wb_we    <= cmd_we;
          last_q   <= cmd_last;
        end else if (xfer) begin
          wb_stb <= 1'b0;
        end
        if (xfer && !term)      out_q <= out_q + ow'(1);
        else if (!xfer && term) out_q <= out_q - ow'(1);
        // Any bus progress (new phase or termination) restarts the deadline.
        if (xfer || term)        timer_q <= '0;
        else if (out_q != '0)    timer_q <= timer_q + tw'(1);
        if (term) begin
          rsp_valid <= 1'b1;
          rsp_err   <= wb_err;
          rsp_dat   <= we_fifo_q[0] ? '0 : wb_dat_i;
        end
        if (state_q == ABORT) begin
          rsp_valid    <= 1'b1;
          rsp_err      <= 1'b1;
          abort_left_q <= abort_left_q - ow'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_master_pipelined.sv
// Self-checking bench for wb_master_pipelined: a pipelined slave model with
// programmable latency, stall, error and no-ack behaviour, a command driver,
// and a response scoreboard.
module tb_wb_master_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_last;
  logic [15:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_err, busy, timeout_flag;
  logic [15:0] rsp_dat;
  logic [15:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_we, wb_cyc, wb_stb, wb_ack, wb_err, wb_stall;

  wb_master_pipelined #(
    .adr_width(16), .dat_width(16), .max_outstanding(4), .timeout(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .busy(busy), .timeout_flag(timeout_flag),
    .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_we(wb_we), .wb_cyc(wb_cyc),
    .wb_stb(wb_stb), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dat;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [15:0] dat;
    logic        err;
    int          due;
  } ph_t;

  int tests = 0;
  int fails = 0;
  int cnt   = 0;

  exp_t sb[$];
  ph_t  ph_q[$];
  logic [15:0] mem [0:255];

  // Slave behaviour knobs.
  int lat        = 1;
  int stall_idx  = -1;
  int stall_left = 0;
  int err_idx    = -1;
  bit no_ack     = 1'b0;

  // Per-test observations.
  int phase_idx, phases, terms, max_out, last_phase_cnt;
  int stb_cycles, first_stb, last_stb, adr12_cycles, cyc_rises, fall_cnt;
  int blocked_cnt;
  bit cyc_prev = 1'b0;
  logic [15:0] phase_adr[$];
  logic [15:0] phase_dat[$];
  int rsp_log[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    phase_idx = 0; phases = 0; terms = 0; max_out = 0; last_phase_cnt = 0;
    stb_cycles = 0; first_stb = -1; last_stb = 0; adr12_cycles = 0;
    cyc_rises = 0; fall_cnt = 0; blocked_cnt = 0;
    phase_adr.delete(); phase_dat.delete(); rsp_log.delete();
  endtask

  // Enter and leave at a negedge; the command is taken at the next posedge
  // once cmd_ready is seen high mid-cycle.
  task automatic send(input logic we, input logic [15:0] adr,
                      input logic [15:0] dat, input logic last,
                      input logic exp_err, input logic [15:0] exp_dat);
    bit   done = 1'b0;
    exp_t e;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    cmd_last = last;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (cmd_ready) begin
        e.dat = exp_dat; e.err = exp_err;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        blocked_cnt++;
      end
      @(negedge clk);
    end
    if (!done) check("cmd_accept_timeout", {31'b0, done}, 1);
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      #1;
      if (sb.size() == 0 && !busy) ok = 1'b1;
      @(negedge clk);
    end
    check("idle_reached", {31'b0, ok}, 1);
  endtask

  initial forever @(posedge clk) cnt++;

  // Pipelined slave: decides stall and captures phases at each negedge,
  // answers each phase in order 'lat' cycles later.
  initial begin
    ph_t p;
    ph_t n;
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
      if (rst) begin
        ph_q.delete();
        wb_stall = 1'b0;
      end else begin
        if (ph_q.size() > 0 && ph_q[0].due <= cnt) begin
          p = ph_q.pop_front();
          if (p.err) wb_err = 1'b1;
          else begin
            wb_ack = 1'b1;
            if (p.we) mem[p.adr[7:0]] = p.dat;
            else      wb_dat_i = mem[p.adr[7:0]];
          end
          terms++;
        end
        if (wb_stb && phase_idx == stall_idx && stall_left > 0) begin
          wb_stall = 1'b1;
          stall_left--;
        end else begin
          wb_stall = 1'b0;
        end
        if (wb_stb && !wb_stall) begin
          phase_adr.push_back(wb_adr);
          phase_dat.push_back(wb_dat_o);
          last_phase_cnt = cnt;
          if (!no_ack) begin
            n.adr = wb_adr; n.we = wb_we; n.dat = wb_dat_o;
            n.err = (phase_idx == err_idx); n.due = cnt + lat;
            ph_q.push_back(n);
          end
          phase_idx++;
          phases++;
        end
        if (phases - terms > max_out) max_out = phases - terms;
      end
    end
  end

  // Response scoreboard and bus observations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_stb) begin
        stb_cycles++;
        if (first_stb < 0) first_stb = cnt;
        last_stb = cnt;
        if (wb_adr == 16'd12) adr12_cycles++;
      end
      if (wb_cyc && !cyc_prev) cyc_rises++;
      if (!wb_cyc && cyc_prev) fall_cnt = cnt;
      cyc_prev = wb_cyc;
      if (rsp_valid) begin
        rsp_log.push_back(cnt);
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("rsp_dat", {16'b0, rsp_dat}, {16'b0, e.dat});
          check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    idle(); cmd_adr = '0; cmd_dat = '0;
    clear_stats();

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_cyc", {31'b0, wb_cyc}, 0);
    check("rst_stb", {31'b0, wb_stb}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_timeout_flag", {31'b0, timeout_flag}, 0);
    check("rst_wb_adr", {16'b0, wb_adr}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check("idle_cmd_ready", {31'b0, cmd_ready}, 1);
    @(negedge clk);

    // Single write; cyc drops one cycle after the ack.
    clear_stats(); lat = 1;
    send(1'b1, 16'd1, 16'd101, 1'b1, 1'b0, 16'd0);
    idle();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (wb_ack) seen = 1'b1;
    end
    check("t1_ack_seen", {31'b0, seen}, 1);
    check("t1_cyc_at_ack", {31'b0, wb_cyc}, 1);
    @(negedge clk); #1;
    check("t1_cyc_after_ack", {31'b0, wb_cyc}, 0);
    check("t1_rsp_pulse", {31'b0, rsp_valid}, 1);
    @(negedge clk);
    wait_idle(50);
    check("t1_stb_cycles", stb_cycles, 1);
    check("t1_phases", phase_adr.size(), 1);
    check("t1_adr", {16'b0, phase_adr[0]}, 1);
    check("t1_dat", {16'b0, phase_dat[0]}, 101);

    // Ten back-to-back writes in one bus cycle.
    clear_stats();
    for (int i = 0; i < 10; i++)
      send(1'b1, 16'(11 + i), 16'(211 + i), i == 9, 1'b0, 16'd0);
    idle();
    wait_idle(100);
    check("t2_stb_cycles", stb_cycles, 10);
    check("t2_stb_span", last_stb - first_stb, 9);
    check("t2_cyc_rises", cyc_rises, 1);
    check("t2_phases", phase_adr.size(), 10);
    for (int i = 0; i < 10; i++)
      check("t2_adr_order", {16'b0, phase_adr[i]}, 11 + i);

    // Reads back with slow acks: outstanding limit must hold at 4.
    clear_stats(); lat = 6;
    for (int i = 0; i < 10; i++)
      send(1'b0, 16'(11 + i), 16'd0, i == 9, 1'b0, 16'(211 + i));
    idle();
    wait_idle(200);
    check("t3_max_outstanding", max_out, 4);
    check("t3_ready_blocked", {31'b0, blocked_cnt > 0}, 1);
    check("t3_phases", phase_adr.size(), 10);
    lat = 1;

    // Three reads, second stalled for 3 cycles.
    clear_stats(); stall_idx = 1; stall_left = 3;
    for (int i = 0; i < 3; i++)
      send(1'b0, 16'(11 + i), 16'd0, i == 2, 1'b0, 16'(211 + i));
    idle();
    wait_idle(100);
    check("t4_stb_cycles", stb_cycles, 6);
    check("t4_adr12_held", adr12_cycles, 4);
    check("t4_phases", phase_adr.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t4_adr_order", {16'b0, phase_adr[i]}, 11 + i);
    stall_idx = -1;

    // Error on the second of three writes.
    clear_stats(); err_idx = 1;
    for (int i = 0; i < 3; i++)
      send(1'b1, 16'(30 + i), 16'(330 + i), i == 2, i == 1, 16'd0);
    idle();
    wait_idle(100);
    check("t5_cyc_dropped", {31'b0, wb_cyc}, 0);
    check("t5_cyc_rises", cyc_rises, 1);
    check("t5_rsp_count", rsp_log.size(), 3);
    err_idx = -1;

    // Slave never answers two reads: timeout abort.
    clear_stats(); no_ack = 1'b1;
    send(1'b0, 16'd40, 16'd0, 1'b0, 1'b1, 16'd0);
    send(1'b0, 16'd41, 16'd0, 1'b1, 1'b1, 16'd0);
    idle();
    wait_idle(100);
    check("t6_cyc_drop_delay", fall_cnt - last_phase_cnt - 1, 9);
    check("t6_err_pulses", rsp_log.size(), 2);
    check("t6_pulses_consecutive", rsp_log[1] - rsp_log[0], 1);
    check("t6_timeout_flag", {31'b0, timeout_flag}, 1);
    check("t6_cyc_low", {31'b0, wb_cyc}, 0);
    no_ack = 1'b0;

    // Asynchronous reset in the middle of a stalled bus cycle.
    clear_stats(); stall_idx = 0; stall_left = 1000;
    send(1'b0, 16'd50, 16'd0, 1'b1, 1'b0, 16'd0);
    idle();
    #1;
    check("t7_stb_before_rst", {31'b0, wb_stb}, 1);
    check("t7_cyc_before_rst", {31'b0, wb_cyc}, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_cyc_async", {31'b0, wb_cyc}, 0);
    check("t7_stb_async", {31'b0, wb_stb}, 0);
    check("t7_busy_async", {31'b0, busy}, 0);
    check("t7_flag_cleared", {31'b0, timeout_flag}, 0);
    check("t7_rsp_valid", {31'b0, rsp_valid}, 0);
    sb.delete();
    stall_left = 0; stall_idx = -1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("t7_ready_after", {31'b0, cmd_ready}, 1);
    check("t7_busy_after", {31'b0, busy}, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_master_pipelined.md
Name: wb_master_pipelined

Overview:
Pipelined Wishbone B4 initiator. It converts a valid/ready command stream into pipelined single transfers and returns read data and completion status on a response stream. It sits between a local requester (DMA, CPU bridge, bench driver) and wb_slave_pipelined or an interconnect. It is the RTL counterpart of the bench tasks that currently drive the slave directly.

Parameters:
adr_width, 16, Wishbone address width
dat_width, 16, Wishbone data width
max_outstanding, 4, maximum accepted-but-unacknowledged transfers (power of 2, 1..16)
timeout, 255, cycles without ack/err while transfers are outstanding before abort (0 = disabled)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
cmd_we  in  1  1 = write, 0 = read
cmd_adr  in  adr_width  transfer address
cmd_dat  in  dat_width  write data
cmd_last  in  1  final transfer of this bus cycle; cyc drops after its completion
rsp_valid  out  1  one-cycle response pulse, no backpressure
rsp_dat  out  dat_width  read data (0 for writes)
rsp_err  out  1  response terminated by err or timeout
busy  out  1  cyc asserted or command pending
timeout_flag  out  1  sticky; set on timeout abort, cleared only by rst
wb_adr  out  adr_width  address
wb_dat_o  out  dat_width  write data
wb_we  out  1  write enable
wb_cyc  out  1  bus cycle
wb_stb  out  1  strobe
wb_dat_i  in  dat_width  read data
wb_ack  in  1  acknowledge
wb_err  in  1  error termination
wb_stall  in  1  slave stall

Behaviour:
- Reset (async): all outputs 0; state IDLE; outstanding = 0; timer = 0; timeout_flag = 0.
- States: IDLE, BUS (cyc = 1, issuing), DRAIN (last issued, waiting for terminations).
- IDLE -> BUS on command acceptance. cyc and stb rise in the following cycle, with adr/we/dat_o registered from the command.
- Phase transfer occurs at a posedge with stb & !stall. stb, adr, we and dat_o hold stable while stall = 1.
- cmd_ready = state != DRAIN & (!stb | !stall) & (outstanding + stb) < max_outstanding. Back-to-back commands issue one per cycle with no stb gap.
- Transfer of a command with cmd_last = 1 -> DRAIN; no further commands are accepted until cyc drops.
- outstanding: +1 on transfer, -1 on ack|err, unchanged on both in the same cycle. ack/err with outstanding = 0 are ignored.
- Responses: rsp_valid pulses the cycle after ack|err (1-cycle latency). rsp_dat = registered wb_dat_i for reads, 0 for writes. rsp_err = err. Per-transfer we is tracked in a max_outstanding-deep shift FIFO. Responses stay in issue order.
- DRAIN -> IDLE: cyc and stb drop the cycle after the termination that brings outstanding to 0. In BUS, cyc stays high while the requester holds cmd_valid low.
- Timer counts cycles with outstanding > 0 and no ack/err, and resets on any ack/err.
- At timer = timeout: drop cyc and stb next cycle; emit one rsp_valid with rsp_err = 1 per outstanding entry on consecutive cycles; set timeout_flag; go to IDLE with outstanding = 0. Any pending un-transferred stb is discarded with no response.
- Reset mid-cycle: cyc and stb drop immediately (async). In-flight transfers are lost.

Test Plan:
- Single write adr=1 dat=101, cmd_last=1, slave acks 1 cycle after phase -> one stb cycle, wb_adr=1, wb_dat_o=101, rsp_valid with rsp_err=0, cyc low 1 cycle after ack.
- 10 back-to-back writes adr 11..20 dat 211..220, last on adr 20, stall=0 -> 10 consecutive stb cycles, single cyc, 10 responses in order.
- Reads adr 11..20 after those writes -> rsp_dat 211..220 in order. outstanding never exceeds 4; cmd_ready deasserts when 4 are pending.
- Slave holds stall=1 for 3 cycles on the 2nd of 3 reads -> adr/stb held for 4 cycles, no skipped or duplicated address, 3 responses.
- err on the 2nd of 3 writes -> responses err = 0/1/0, cyc still drops normally.
- timeout=8 and slave never acks 2 issued reads -> cyc drops 9 cycles after the last phase, 2 rsp_err pulses, timeout_flag=1. rst assertion mid-BUS clears all outputs immediately.
